// File: rtl/demod_pkg.sv
// Shared types and elaboration-time helpers for the segment-bank demodulator.
// The soft-decision variant is selected with the DEMOD_SOFT_EN macro (see demod_slicer).
package demod_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic signed [63:0] one_fx(input int unsigned frac);
      return 64'sd1 <<< frac;
   endfunction

   // Reference level of segment k, sign-extended from `width` bits into 64.
   function automatic logic signed [63:0] ref_val(input int unsigned k,
                                                  input int unsigned ref_start_pos,
                                                  input int unsigned width,
                                                  input int unsigned frac);
      logic signed [63:0] v;
      v = (((k % 2) == 0) == (ref_start_pos != 0)) ? one_fx(frac) : -one_fx(frac);
      return (v <<< (64 - width)) >>> (64 - width);
   endfunction

   function automatic int unsigned acc_w(input int unsigned width, input int unsigned sps);
      return width + $clog2(sps) + 1;
   endfunction

endpackage

// File: rtl/demod_slicer.sv
// Combinational per-segment decision: hard +/-ref by default, or the clipped soft sum
// signed towards the reference when DEMOD_SOFT_EN is defined.
module demod_slicer
   import demod_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ACC_W = 34
) (
   input  logic signed [ACC_W-1:0] sum,
   input  logic        [WIDTH-1:0] ref_p,
   input  logic        [WIDTH-1:0] ref_m,
   output logic        [WIDTH-1:0] decision
);

`ifdef DEMOD_SOFT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({(WIDTH-1){1'b1}});
   localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

   logic signed [ACC_W-1:0] clip;
   logic        [WIDTH-1:0] mag;

   always_comb begin
      clip = sum;
      if (sum > SAT_HI) begin
         clip = SAT_HI;
      end else if (sum < SAT_LO) begin
         clip = SAT_LO;
      end
      mag = WIDTH'(clip);
      // Symmetric clip range keeps the negation free of overflow.
      decision = ($signed(ref_p) > $signed(ref_m)) ? mag : -mag;
   end
`else
   // A tie (sum == 0) falls to the mirrored reference.
   assign decision = (!sum[ACC_W-1] && (sum != '0)) ? ref_p : ref_m;
`endif

endmodule

// File: rtl/demod_segment_bank.sv
// Frame-level hard/soft demodulator: accumulates SPS samples per segment over NUM_SEG
// segments and registers each slice decision. Soft output is enabled by DEMOD_SOFT_EN.
module demod_segment_bank
   import demod_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned FRAC          = 16,
   parameter int unsigned NUM_SEG       = 10,
   parameter int unsigned SPS           = 1,
   parameter int unsigned REF_START_POS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WIDTH-1:0]         input_bit,
   input  logic                     sample_valid,
   output logic [NUM_SEG*WIDTH-1:0] segment_out,
   output logic                     valid,
   output logic                     busy
);

   localparam int unsigned AW    = acc_w(WIDTH, SPS);
   localparam int unsigned SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam int unsigned SMP_W = (SPS > 1) ? $clog2(SPS) : 1;

   state_t                   state_q;
   logic [SEG_W-1:0]         seg_q;
   logic [SMP_W-1:0]         smp_q;
   logic signed [AW-1:0]     acc_q;
   logic [NUM_SEG*WIDTH-1:0] seg_out_q;
   logic                     valid_q;
   logic                     busy_q;

   logic signed [AW-1:0]     sum;
   logic [WIDTH-1:0]         ref_p;
   logic [WIDTH-1:0]         ref_m;
   logic [WIDTH-1:0]         decision;
   logic                     smp_last;
   logic                     seg_last;

   always_comb begin
      sum      = acc_q + AW'($signed(input_bit));
      ref_p    = WIDTH'(ref_val(32'(seg_q), REF_START_POS, WIDTH, FRAC));
      ref_m    = -ref_p;
      smp_last = (smp_q == SMP_W'(SPS - 1));
      seg_last = (seg_q == SEG_W'(NUM_SEG - 1));
   end

   demod_slicer #(
      .WIDTH(WIDTH),
      .ACC_W(AW)
   ) u_slicer (
      .sum     (sum),
      .ref_p   (ref_p),
      .ref_m   (ref_m),
      .decision(decision)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         seg_q     <= '0;
         smp_q     <= '0;
         acc_q     <= '0;
         seg_out_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               // DONE accepts start too, giving back-to-back frames.
               if (start) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  seg_out_q <= '0;
                  seg_q     <= '0;
                  smp_q     <= '0;
                  acc_q     <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (sample_valid) begin
                  if (smp_last) begin
                     seg_out_q[int'(seg_q)*WIDTH +: WIDTH] <= decision;
                     acc_q <= '0;
                     smp_q <= '0;
                     if (seg_last) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        seg_q   <= '0;
                     end else begin
                        seg_q <= seg_q + 1'b1;
                     end
                  end else begin
                     acc_q <= sum;
                     smp_q <= smp_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign segment_out = seg_out_q;
   assign valid       = valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_demod_segment_bank.sv
// Scoreboard bench: two instances (default and NUM_SEG=2/SPS=4); frame tasks queue
// expected outputs and valid cycles, a negedge monitor pops and compares on each valid.
module tb_demod_segment_bank;

   localparam logic [319:0] P_ALT = {5{32'hFFFF0000, 32'h00010000}};
   localparam logic [319:0] M_ALT = {5{32'h00010000, 32'hFFFF0000}};
   localparam logic [319:0] E_MIX = {32'h00010000, 32'h00010000, 32'hFFFF0000, 32'hFFFF0000,
                                     32'h00010000, 32'h00010000, 32'h00010000, 32'hFFFF0000,
                                     32'hFFFF0000, 32'h00010000};
   localparam logic [319:0] E_PART = {160'h0, 32'h00010000, 32'hFFFF0000, 32'h00010000,
                                      32'hFFFF0000, 32'h00010000};

   typedef struct {
      logic [319:0] seg;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_a = 1'b0, sv_a = 1'b0, start_b = 1'b0, sv_b = 1'b0;
   logic [31:0]  in_a = '0, in_b = '0;
   logic [319:0] seg_a;
   logic [63:0]  seg_b;
   logic         valid_a, busy_a, valid_b, busy_b;

   int           cyc = 0;
   int           n_total = 0;
   int           n_pass = 0;
   int           busy_cnt_a = 0;
   exp_t         qa[$];
   exp_t         qb[$];
   logic [31:0]  samp_a[10];
   logic [31:0]  samp_b[8];

   demod_segment_bank u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .start       (start_a),
      .input_bit   (in_a),
      .sample_valid(sv_a),
      .segment_out (seg_a),
      .valid       (valid_a),
      .busy        (busy_a)
   );

   demod_segment_bank #(
      .NUM_SEG(2),
      .SPS    (4)
   ) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .start       (start_b),
      .input_bit   (in_b),
      .sample_valid(sv_b),
      .segment_out (seg_b),
      .valid       (valid_b),
      .busy        (busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (valid_a) begin
            if (qa.size() == 0) begin
               n_total++;
               $display("FAIL a_unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
               e = qa.pop_front();
               check("a_segments", seg_a, e.seg);
               check("a_valid_cycle", 320'(cyc), 320'(e.cyc));
               check("a_busy_at_valid", 320'(busy_a), 320'(0));
               check("a_busy_len", 320'(busy_cnt_a), 320'(10));
            end
         end
         if (valid_b) begin
            if (qb.size() == 0) begin
               n_total++;
               $display("FAIL b_unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
               e = qb.pop_front();
               check("b_segments", 320'(seg_b), e.seg);
               check("b_valid_cycle", 320'(cyc), 320'(e.cyc));
               check("b_busy_at_valid", 320'(busy_b), 320'(0));
            end
         end
      end
      busy_cnt_a <= busy_a ? busy_cnt_a + 1 : 0;
   end

   task automatic idle(input int n);
      repeat (n) begin
         sv_a = 1'b1; in_a = 32'h7FFFFFFF; start_a = 1'b0;
         sv_b = 1'b1; in_b = 32'h80000000; start_b = 1'b0;
         @(posedge clk); #1;
      end
      sv_a = 1'b0; sv_b = 1'b0;
   endtask

   // Called #1 after an edge; drives start immediately so a call right after a frame
   // lands in that frame's DONE cycle.
   task automatic frame_a(input logic [319:0] exp, input int mid_start);
      exp_t e;
      start_a = 1'b1; sv_a = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      check("a_busy_after_start", 320'(busy_a), 320'(1));
      check("a_cleared_after_start", seg_a, 320'(0));
      for (int i = 0; i < 10; i++) begin
         sv_a = 1'b1; in_a = samp_a[i]; start_a = (i == mid_start);
         if (i == 9) begin
            e.seg = exp; e.cyc = cyc + 1; qa.push_back(e);
         end
         @(posedge clk); #1;
      end
      sv_a = 1'b0; start_a = 1'b0;
   endtask

   task automatic frame_b(input logic [63:0] exp, input bit gaps);
      exp_t e;
      start_b = 1'b1; sv_b = 1'b0;
      @(posedge clk); #1;
      start_b = 1'b0;
      check("b_busy_after_start", 320'(busy_b), 320'(1));
      for (int i = 0; i < 8; i++) begin
         sv_b = 1'b1; in_b = samp_b[i];
         if (i == 7) begin
            e.seg = 320'(exp); e.cyc = cyc + 1; qb.push_back(e);
         end
         @(posedge clk); #1;
         if (gaps) begin
            sv_b = 1'b0; in_b = 32'h7FFFFFFF;
            @(posedge clk); #1;
         end
      end
      sv_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end expected end");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("a_reset_seg", seg_a, 320'(0));
      check("a_reset_valid", 320'(valid_a), 320'(0));
      check("a_reset_busy", 320'(busy_a), 320'(0));
      check("b_reset_seg", 320'(seg_b), 320'(0));
      check("b_reset_busy", 320'(busy_b), 320'(0));

      idle(2);
      samp_a = '{default: 32'h00010000};
      frame_a(P_ALT, 4);
      idle(3);
      samp_a = '{default: 32'hFFFF8000};
      samp_a[3] = 32'h00000000;
      frame_a(M_ALT, -1);
      samp_a = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h80000000,
                 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFF};
      frame_a(E_MIX, -1);
      idle(3);

      samp_b = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
                 32'hFFFFFFFC, 32'd1, 32'd1, 32'd1};
      frame_b({32'h00010000, 32'hFFFF0000}, 1'b1);
      idle(2);
      samp_b = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      frame_b({32'h00010000, 32'h00010000}, 1'b0);
      idle(2);

      // Abort a frame after five segments.
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sv_a = 1'b1; in_a = 32'h00010000;
         @(posedge clk); #1;
      end
      check("a_partial_frame", seg_a, E_PART);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; sv_a = 1'b0;
      check("a_abort_seg", seg_a, 320'(0));
      check("a_abort_valid", 320'(valid_a), 320'(0));
      check("a_abort_busy", 320'(busy_a), 320'(0));
      idle(4);
      samp_a = '{default: 32'h00010000};
      frame_a(P_ALT, -1);
      idle(4);

      check("a_pending_frames", 320'(qa.size()), 320'(0));
      check("b_pending_frames", 320'(qb.size()), 320'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
